// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcodes, FSM states, frame widths and command builder for the SPI RAM master
package spi_ram_pkg;
   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;
   localparam int CMD_BITS  = 10;
   localparam int DATA_BITS = 8;
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;
   // 10-bit frame word: first frame carries the address, second the data (or zero filler on reads)
   function automatic logic [CMD_BITS-1:0] frame_cmd(input logic is_write, input logic second,
                                                     input logic [DATA_BITS-1:0] addr,
                                                     input logic [DATA_BITS-1:0] wdata);
      return second ? (is_write ? {OP_WR_DATA, wdata} : {OP_RD_DATA, DATA_BITS'(0)})
                    : {(is_write ? OP_WR_ADDR : OP_RD_ADDR), addr};
   endfunction
endpackage

// File: rtl/spi_ram_master_sck_gen.sv
// spi_sck_gen: SCK half-period divider producing the mode-0 clock and its rise/fall strikes
module spi_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_run,
   output logic o_tick,
   output logic o_rise,
   output logic o_fall,
   output logic o_sck
);
   logic [7:0] r_div;
   logic       r_sck;
   assign o_tick = (r_div == 8'(CLK_DIV - 1));
   assign o_rise = o_tick & i_run & ~r_sck;
   assign o_fall = o_tick & i_run & r_sck;
   assign o_sck  = r_sck;
   // divider restarts on every state change so each state spans whole half-periods
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_div <= '0;
      else        r_div <= (i_clr | o_tick) ? '0 : r_div + 8'd1;
   // sck toggles at half-period boundaries only while shifting, so it always parks low
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                r_sck <= 1'b0;
      else if (o_rise | o_fall)  r_sck <= ~r_sck;
endmodule

// File: rtl/spi_ram_master.sv
// spi_ram_master: two-frame SPI RAM read/write master; SPI_RAM_MASTER_GAP_EN lengthens the inter-frame gap by GAP_HP half-periods
module spi_ram_master #(
   parameter int CLK_DIV = 2,
   parameter int GAP_HP  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       sck,
   output logic       ss_n,
   output logic       mosi,
   input  logic       miso
);
   import spi_ram_pkg::*;
`ifdef SPI_RAM_MASTER_GAP_EN
   localparam int GAP_LEN = 2 + GAP_HP;
`else
   localparam int GAP_LEN = 2;
`endif
   state_t                r_state, w_next;
   logic                  r_write, r_second, r_rsp_valid;
   logic [DATA_BITS-1:0]  r_addr, r_wdata, r_rx, r_rsp_data;
   logic [CMD_BITS-1:0]   r_sh, w_cmd;
   logic [4:0]            r_cnt;
   logic [7:0]            r_gap;
   logic                  w_accept, w_rd2, w_last, w_gap_done, w_load, w_clr;
   logic                  w_tick, w_rise, w_fall, w_sck;
   assign w_accept   = req_valid & req_ready;
   assign w_rd2      = ~r_write & r_second;
   assign w_last     = (r_cnt == (w_rd2 ? 5'd18 : 5'd9));
   assign w_gap_done = (r_gap == 8'(GAP_LEN - 1));
   assign w_load     = (w_next == ST_SETUP) & (r_state != ST_SETUP);
   assign w_clr      = (w_next != r_state) | (r_state == ST_IDLE);
   assign w_cmd      = (r_state == ST_IDLE) ? frame_cmd(req_write, 1'b0, req_addr, req_wdata)
                                            : frame_cmd(r_write, 1'b1, r_addr, r_wdata);
   assign req_ready  = (r_state == ST_IDLE);
   assign ss_n       = (r_state == ST_IDLE) | (r_state == ST_GAP);
   assign mosi       = r_sh[CMD_BITS-1];
   assign sck        = w_sck;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_clr),
      .i_run (r_state == ST_SHIFT),
      .o_tick(w_tick),
      .o_rise(w_rise),
      .o_fall(w_fall),
      .o_sck (w_sck)
   );
   // next-state: every timed state advances on a half-period tick, SHIFT on its final falling edge
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  w_next = w_accept ? ST_SETUP : ST_IDLE;
         ST_SETUP: w_next = w_tick ? ST_SHIFT : ST_SETUP;
         ST_SHIFT: w_next = (w_fall & w_last) ? ST_HOLD : ST_SHIFT;
         ST_HOLD:  w_next = w_tick ? ST_GAP : ST_HOLD;
         ST_GAP:   w_next = (w_tick & w_gap_done) ? (r_second ? ST_IDLE : ST_SETUP) : ST_GAP;
         default:  w_next = ST_IDLE;
      endcase
   end
   // state register, request capture and first/second frame tracking
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_second <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_second <= 1'b0;
         end else if (r_state == ST_GAP && w_next == ST_SETUP) r_second <= 1'b1;
      end
   // command shifter loads on SETUP entry and advances on sck falls; zeros fill behind so mosi rests low
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_sh  <= '0;
         r_cnt <= '0;
         r_gap <= '0;
      end else begin
         if (w_load)      r_sh <= w_cmd;
         else if (w_fall) r_sh <= {r_sh[CMD_BITS-2:0], 1'b0};
         if (w_fall)      r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
         if (r_state == ST_GAP && w_tick) r_gap <= w_gap_done ? 8'd0 : r_gap + 8'd1;
      end
   // read data: miso sampled on rises 12..19 of a read data frame, published when HOLD ends
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rx        <= '0;
         r_rsp_data  <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_rise & w_rd2 & (r_cnt >= 5'd11)) r_rx <= {r_rx[DATA_BITS-2:0], miso};
         if ((r_state == ST_HOLD) & w_tick & w_rd2) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rx;
         end
      end
endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: bench for spi_ram_master at CLK_DIV 2, 1 and 7 with an SPI RAM slave and timing monitor
module tb_spi_ram_master;
   localparam int DIVS [3] = '{2, 1, 7};
`ifdef SPI_RAM_MASTER_GAP_EN
   localparam int GAPC = 6;
`else
   localparam int GAPC = 2;
`endif
   logic       clk, rst_n, req_valid, req_write, miso;
   logic [7:0] req_addr, req_wdata;
   logic       ready_a [3], rsp_valid_a [3], sck_a [3], ss_n_a [3], mosi_a [3];
   logic [7:0] rsp_data_a [3];
   int         cur = 0;
   int         checks = 0, failures = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      spi_ram_master #(.CLK_DIV(DIVS[g]), .GAP_HP(4)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .req_valid(req_valid && (cur == g)),
         .req_ready(ready_a[g]),
         .req_write(req_write),
         .req_addr (req_addr),
         .req_wdata(req_wdata),
         .rsp_valid(rsp_valid_a[g]),
         .rsp_data (rsp_data_a[g]),
         .sck      (sck_a[g]),
         .ss_n     (ss_n_a[g]),
         .mosi     (mosi_a[g]),
         .miso     (miso)
      );
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // monitor / slave model state
   int         cyc = 0, acc_cyc, fi, rises, t_ssl, t_ssh, t_rise, t_fall, rsp_n, p_cur = -1;
   logic       busy = 1'b0, p_acc, p_sck, p_ss, p_mosi, c_w, inited = 1'b0;
   logic [7:0] c_a, c_d, sl_addr, rdata, last_rsp;
   logic [9:0] cmd;
   logic [7:0] mem [256];
   logic [7:0] model [256];
   always @(negedge clk) begin
      logic       sck, ss, mo, rdy, rv;
      logic [7:0] rd;
      int         d;
      sck = sck_a[cur]; ss = ss_n_a[cur]; mo = mosi_a[cur];
      rdy = ready_a[cur]; rv = rsp_valid_a[cur]; rd = rsp_data_a[cur];
      d = DIVS[cur];
      cyc++;
      if (!inited) begin
         for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'(i) ^ 8'h99;
            model[i] = 8'(i) ^ 8'h99;
         end
         inited = 1'b1;
      end
      if (!rst_n || cur != p_cur) begin
         busy = 1'b0; fi = 0; p_acc = 1'b0; p_cur = cur; miso = 1'b0; rsp_n = 0;
      end else begin
         if (ss) chk("mosi_idle", mo, 0);
         if (mo !== p_mosi) chk("mosi_chg_sck_low", sck, 0);
         if (p_acc) chk("ready_drop", rdy, 0);
         p_acc = 1'b0;
         if (p_ss && !ss) begin
            chk("ss_only_busy", busy, 1);
            if (fi == 1) chk("gap_len", cyc - t_ssh, GAPC * d);
            rises = 0; cmd = '0; t_ssl = cyc;
         end
         if (!p_sck && sck) begin
            rises++;
            chk("lo_len", cyc - (rises == 1 ? t_ssl : t_fall), rises == 1 ? 2 * d : d);
            chk("mosi_stable", mo, p_mosi);
            if (rises <= 10) cmd = {cmd[8:0], mo};
            if (rises == 10 && cmd[9:8] == 2'b11) rdata = mem[sl_addr];
            t_rise = cyc;
         end
         if (p_sck && !sck) begin
            chk("hi_len", cyc - t_rise, d);
            t_fall = cyc;
            miso = (rises >= 11 && rises <= 18 && cmd[9:8] == 2'b11) ? rdata[18 - rises] : 1'b0;
         end
         if (!p_ss && ss) begin
            chk("hold_len", cyc - t_fall, d);
            chk("pulses", rises, (!c_w && fi == 1) ? 19 : 10);
            chk("frame_cmd", cmd, fi == 0 ? {(c_w ? 2'b00 : 2'b10), c_a} : (c_w ? {2'b01, c_d} : 10'h300));
            if (cmd[9:8] == 2'b00 || cmd[9:8] == 2'b10) sl_addr = cmd[7:0];
            if (cmd[9:8] == 2'b01) mem[sl_addr] = cmd[7:0];
            fi++; t_ssh = cyc;
         end
         if (rv) begin
            chk("rsp_when_read", busy && !c_w && rsp_n == 0, 1);
            chk("rsp_lat", cyc - acc_cyc, (62 + GAPC) * d + 1);
            chk("rsp_data", rd, model[c_a]);
            rsp_n++; last_rsp = rd;
         end
         if (busy && rdy) begin
            chk("latency", cyc - acc_cyc, (c_w ? 2 * (22 + GAPC) : 62 + 2 * GAPC) * d + 1);
            chk("frames", fi, 2);
            chk("rsp_count", rsp_n, c_w ? 0 : 1);
            busy = 1'b0;
         end
         if (!busy) chk("ready_idle", rdy, 1);
         if (req_valid && rdy) begin
            busy = 1'b1; p_acc = 1'b1; acc_cyc = cyc; fi = 0; rsp_n = 0;
            c_w = req_write; c_a = req_addr; c_d = req_wdata;
            if (c_w) model[c_a] = c_d;
         end
      end
      p_sck = sck; p_ss = ss; p_mosi = mo;
   end
   task automatic send(input logic w, input logic [7:0] a, input logic [7:0] dat, input logic hold);
      int n = 0;
      req_write = w; req_addr = a; req_wdata = dat; req_valid = 1'b1;
      while (!ready_a[cur] && n < 5000) begin @(posedge clk); #1; n++; end
      chk("send_timeout", n < 5000, 1);
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((busy || !ready_a[cur]) && n < 5000) begin @(posedge clk); #1; n++; end
      chk("idle_timeout", n < 5000, 1);
   endtask
   task automatic rand_ops(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         send(1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 7)), 8'($urandom), 1'b0);
         wait_idle();
      end
   endtask
   task automatic check_reset_outputs(input int i);
      chk("rst_sck", sck_a[i], 0);
      chk("rst_ss_n", ss_n_a[i], 1);
      chk("rst_mosi", mosi_a[i], 0);
      chk("rst_ready", ready_a[i], 1);
      chk("rst_rsp_valid", rsp_valid_a[i], 0);
      chk("rst_rsp_data", rsp_data_a[i], 8'h00);
   endtask
   initial begin
      int n;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) check_reset_outputs(i);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send(1'b0, 8'h5A, 8'h00, 1'b0);
      wait_idle();
      chk("read_5a", last_rsp, 8'hC3);
      send(1'b1, 8'hA5, 8'h3C, 1'b0);
      wait_idle();
      send(1'b0, 8'hA5, 8'h00, 1'b0);
      wait_idle();
      chk("readback_a5", last_rsp, 8'h3C);
      send(1'b1, 8'h41, 8'($urandom), 1'b1);
      send(1'b0, 8'h41, 8'h00, 1'b1);
      send(1'b0, 8'($urandom), 8'h00, 1'b0);
      wait_idle();
      rand_ops(8);
      send(1'b0, 8'h11, 8'h00, 1'b0);
      n = 0;
      while (!(fi == 1 && rises == 5 && sck_a[cur]) && n < 2000) begin @(posedge clk); #1; n++; end
      chk("pulse5_reached", n < 2000, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs(0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      send(1'b1, 8'h22, 8'h44, 1'b0);
      wait_idle();
      send(1'b0, 8'h22, 8'h00, 1'b0);
      wait_idle();
      chk("after_reset_read", last_rsp, 8'h44);
      cur = 1;
      @(posedge clk); #1;
      rand_ops(6);
      cur = 2;
      @(posedge clk); #1;
      rand_ops(4);
      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
